// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder sequencer.
// State encoding and the full-adder cell's worst-case path delay.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sa_state_t;

    localparam int FA_PATH_PS = 150;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Team full-adder cell: one bit of sum and carry.
// Shared by the serial sequencer for every operand bit.
module fa (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    logic p;

    assign p    = a_i ^ b_i;
    assign s_o  = p ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: operands are shifted LSB-first through
// one fa cell; the result is published only once all bits are done.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             fa_s, fa_co;

    fa u_fa (
        .a_i  (a_sh_q[0]),
        .b_i  (b_sh_q[0]),
        .ci_i (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    carry_d  = cin;
                    cnt_d    = '0;
                    sum_sh_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_co;
                // carry_q here is the carry into the MSB
                if (cnt_q == LAST) begin
                    sum_d   = sum_sh_d;
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed checks of the serial adder at WIDTH=8 and WIDTH=2.
module tb_serial_add_ctrl;

    logic       clk;
    logic       reset;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, sum;
    logic       cin, cout, ovf, busy;

    logic       w2_in_valid, w2_in_ready, w2_out_valid, w2_out_ready;
    logic [1:0] w2_a, w2_b, w2_sum;
    logic       w2_cin, w2_cout, w2_ovf, w2_busy;

    int n_chk, n_pass;
    int lat;
    int idx, got, cyc, last_t;
    logic prev_rdy;
    logic [8:0] exp9;
    logic [8:0] q_sum[$];
    logic       q_ovf[$];

    localparam int NV = 192;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (w2_in_valid),
        .in_ready  (w2_in_ready),
        .a         (w2_a),
        .b         (w2_b),
        .cin       (w2_cin),
        .out_valid (w2_out_valid),
        .out_ready (w2_out_ready),
        .sum       (w2_sum),
        .cout      (w2_cout),
        .ovf       (w2_ovf),
        .busy      (w2_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got_v,
                       input logic [31:0] exp_v);
        n_chk++;
        if (got_v === exp_v) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_v,
                            input logic tc);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("start_rdy", {31'd0, in_ready}, 32'd1);
        a = ta;
        b = tb_v;
        cin = tc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (!out_valid && l < 50) begin
            tick();
            l++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        w2_in_valid = 1'b0;
        w2_out_ready = 1'b0;
        w2_a = '0;
        w2_b = '0;
        w2_cin = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_res", {23'd0, ovf, cout, sum}, 32'd0);

        // 0F + 01
        start_op(8'h0F, 8'h01, 1'b0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_in_ready", {31'd0, in_ready}, 32'd0);
        wait_done(lat);
        chk("t1_lat", lat, 32'd8);
        chk("t1_sum", {24'd0, sum}, 32'h10);
        chk("t1_cout", {31'd0, cout}, 32'd0);
        chk("t1_ovf", {31'd0, ovf}, 32'd0);
        drain();
        chk("t1_drop", {31'd0, out_valid}, 32'd0);
        chk("t1_idle", {31'd0, in_ready}, 32'd1);
        chk("t1_hold", {24'd0, sum}, 32'h10);

        // FF + 01 wraps with carry out
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(lat);
        chk("t2a_lat", lat, 32'd8);
        chk("t2a_sum", {24'd0, sum}, 32'h00);
        chk("t2a_cout", {31'd0, cout}, 32'd1);
        chk("t2a_ovf", {31'd0, ovf}, 32'd0);
        drain();

        // 7F + 01 signed overflow
        start_op(8'h7F, 8'h01, 1'b0);
        wait_done(lat);
        chk("t2b_sum", {24'd0, sum}, 32'h80);
        chk("t2b_cout", {31'd0, cout}, 32'd0);
        chk("t2b_ovf", {31'd0, ovf}, 32'd1);
        drain();

        // Stall in DONE with stray in_valid pulses
        start_op(8'h80, 8'h80, 1'b0);
        wait_done(lat);
        chk("t3_lat", lat, 32'd8);
        for (int i = 0; i < 5; i++) begin
            a = 8'h55;
            b = 8'h11;
            in_valid = i[0];
            tick();
            chk("t3_valid", {31'd0, out_valid}, 32'd1);
            chk("t3_ready", {31'd0, in_ready}, 32'd0);
            chk("t3_res", {23'd0, ovf, cout, sum}, {23'd0, 1'b1, 1'b1, 8'h00});
        end
        in_valid = 1'b0;
        drain();
        chk("t3_idle", {31'd0, in_ready}, 32'd1);
        chk("t3_busy", {31'd0, busy}, 32'd0);

        // Reset at cnt=3 of RUN
        start_op(8'hAA, 8'h55, 1'b0);
        tick();
        tick();
        tick();
        chk("t4_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4_rdy", {31'd0, in_ready}, 32'd1);
        chk("t4_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_busy0", {31'd0, busy}, 32'd0);
        chk("t4_res", {23'd0, ovf, cout, sum}, 32'd0);
        start_op(8'h12, 8'h34, 1'b1);
        wait_done(lat);
        chk("t4_lat", lat, 32'd8);
        chk("t4_sum", {24'd0, sum}, 32'h47);
        chk("t4_cout", {31'd0, cout}, 32'd0);
        drain();

        // Back-to-back streaming over a grid of operands
        idx = 0;
        got = 0;
        cyc = 0;
        last_t = -1;
        a = 8'(((idx / 12) % 16) * 17);
        b = 8'(((idx / 2) % 6) * 51);
        cin = idx[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        prev_rdy = in_ready;
        while (got < NV && cyc < 4000) begin
            tick();
            cyc++;
            if (out_valid) begin
                if (q_sum.size() == 0) begin
                    chk("b2b_extra", 32'd1, 32'd0);
                end else begin
                    chk("b2b_sum", {23'd0, cout, sum}, {23'd0, q_sum.pop_front()});
                    chk("b2b_ovf", {31'd0, ovf}, {31'd0, q_ovf.pop_front()});
                end
                if (last_t >= 0) chk("b2b_ii", cyc - last_t, 32'd10);
                last_t = cyc;
                got++;
            end
            if (prev_rdy && !in_ready && idx < NV) begin
                exp9 = {1'b0, a} + {1'b0, b} + {8'd0, cin};
                q_sum.push_back(exp9);
                q_ovf.push_back((a[7] == b[7]) && (exp9[7] != a[7]));
                idx++;
                if (idx == NV) begin
                    in_valid = 1'b0;
                end else begin
                    a = 8'(((idx / 12) % 16) * 17);
                    b = 8'(((idx / 2) % 6) * 51);
                    cin = idx[0];
                end
            end
            prev_rdy = in_ready;
        end
        chk("b2b_count", got, NV);
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();

        // WIDTH=2: 3 + 3 + 1
        chk("w2_rdy", {31'd0, w2_in_ready}, 32'd1);
        w2_a = 2'b11;
        w2_b = 2'b11;
        w2_cin = 1'b1;
        w2_in_valid = 1'b1;
        tick();
        w2_in_valid = 1'b0;
        lat = 0;
        while (!w2_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("w2_lat", lat, 32'd2);
        chk("w2_sum", {30'd0, w2_sum}, 32'd3);
        chk("w2_cout", {31'd0, w2_cout}, 32'd1);
        chk("w2_ovf", {31'd0, w2_ovf}, 32'd0);
        w2_out_ready = 1'b1;
        tick();
        w2_out_ready = 1'b0;
        chk("w2_drop", {31'd0, w2_out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
